// File: rtl/bp_me_mem_delay_fifo.sv
// Latency-injection FIFO between CCE memory-command outputs and the memory model.
// Optional statistics (occ_max_o, stall_cnt_o) are built when BP_ME_MEM_DELAY_STATS_EN is defined.
module bp_me_mem_delay_fifo #(
  parameter int unsigned width_p       = 128,
  parameter int unsigned els_p         = 4,
  parameter int unsigned delay_width_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [delay_width_p-1:0]     delay_i,
  input  logic [width_p-1:0]           data_i,
  input  logic                         v_i,
  output logic                         yumi_o,
  output logic [width_p-1:0]           data_o,
  output logic                         v_o,
  input  logic                         yumi_i,
  output logic [$clog2(els_p+1)-1:0]   occ_max_o,
  output logic [31:0]                  stall_cnt_o
);

  localparam int unsigned ptr_w_lp = $clog2(els_p);
  localparam int unsigned occ_w_lp = $clog2(els_p+1);

  typedef logic [ptr_w_lp-1:0] ptr_t;
  typedef logic [occ_w_lp-1:0] occ_t;

  typedef enum logic [1:0] {
    E_EMPTY = 2'd0,
    E_WAIT  = 2'd1,
    E_READY = 2'd2
  } entry_state_e;

  entry_state_e             state_r [els_p];
  entry_state_e             state_n [els_p];
  logic [delay_width_p-1:0] cnt_r   [els_p];
  logic [delay_width_p-1:0] cnt_n   [els_p];
  logic [width_p-1:0]       mem_r   [els_p];

  ptr_t head_r, head_n;
  ptr_t tail_r, tail_n;
  occ_t occ_r, occ_n;
  logic full, enq, deq;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(els_p-1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Full comes from registered occupancy only, so yumi_i never reaches yumi_o.
  assign full   = (occ_r == occ_t'(els_p));
  assign yumi_o = reset_n_i & v_i & ~full;
  assign v_o    = (state_r[head_r] == E_READY);
  assign data_o = mem_r[head_r];
  assign enq    = yumi_o;
  assign deq    = yumi_i & v_o;

  always_comb begin
    for (int unsigned i = 0; i < els_p; i++) begin
      state_n[i] = state_r[i];
      cnt_n[i]   = cnt_r[i];
      if (state_r[i] == E_WAIT) begin
        cnt_n[i] = cnt_r[i] - delay_width_p'(1);
        if (cnt_r[i] == delay_width_p'(1))
          state_n[i] = E_READY;
      end
    end
    if (deq)
      state_n[head_r] = E_EMPTY;
    if (enq) begin
      state_n[tail_r] = (delay_i == '0) ? E_READY : E_WAIT;
      cnt_n[tail_r]   = delay_i;
    end
  end

  always_comb begin
    head_n = deq ? ptr_inc(head_r) : head_r;
    tail_n = enq ? ptr_inc(tail_r) : tail_r;
    case ({enq, deq})
      2'b10:   occ_n = occ_r + occ_t'(1);
      2'b01:   occ_n = occ_r - occ_t'(1);
      default: occ_n = occ_r;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < els_p; i++) begin
        state_r[i] <= E_EMPTY;
        cnt_r[i]   <= '0;
      end
      head_r <= '0;
      tail_r <= '0;
      occ_r  <= '0;
    end else begin
      for (int unsigned i = 0; i < els_p; i++) begin
        state_r[i] <= state_n[i];
        cnt_r[i]   <= cnt_n[i];
      end
      head_r <= head_n;
      tail_r <= tail_n;
      occ_r  <= occ_n;
    end
  end

  // Payload storage needs no reset; validity is carried by the entry state.
  always_ff @(posedge clk_i) begin
    if (enq)
      mem_r[tail_r] <= data_i;
  end

`ifdef BP_ME_MEM_DELAY_STATS_EN
  occ_t        occ_max_r;
  logic [31:0] stall_cnt_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      occ_max_r   <= '0;
      stall_cnt_r <= '0;
    end else begin
      if (occ_n > occ_max_r)
        occ_max_r <= occ_n;
      if (v_i && !yumi_o && (stall_cnt_r != '1))
        stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign occ_max_o   = occ_max_r;
  assign stall_cnt_o = stall_cnt_r;
`else
  assign occ_max_o   = '0;
  assign stall_cnt_o = '0;
`endif

  a_yumi_only_when_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o
  );

endmodule
